// File: rtl/rs_encoder_if.sv
// rtl/rs_encoder_if.sv - message-in / codeword-out stream bundle for rs_encoder
interface rs_encoder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_parity;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_parity, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_parity, out_last
  );
endinterface

// File: rtl/rs_encoder.sv
// rtl/rs_encoder.sv - systematic RS(K+6,K) encoder over GF(2^8), t = 3
module multiply (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add product, reducing by x^8+x^4+x^3+x^2+1 whenever the shifted operand overflows
  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    y = acc;
  end
endmodule

module rs_encoder #(
  parameter int K = 249
) (
  input logic         clk,
  input logic         rst_n,
  rs_encoder_if.slave bus
);
  localparam logic [0:0] ST_MSG   = 1'b0;
  localparam logic [0:0] ST_PAR   = 1'b1;
  localparam logic [7:0] MSG_LAST = 8'(K - 1);

  logic [0:0] state;
  logic [7:0] msg_cnt;
  logic [2:0] par_cnt;
  logic [7:0] r5, r4, r3, r2, r1, r0;
  logic [7:0] fb;
  logic [7:0] p5, p4, p3, p2, p1, p0;
  logic       free;

  // The output register can take a new byte when empty or being drained this cycle
  assign free         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == ST_MSG) && free;

  // Feedback of the divider: incoming message byte plus the top remainder byte
  assign fb = bus.in_data ^ r5;

  // Constant-coefficient taps of g(x) = x^6 + 3F x^5 + 01 x^4 + DA x^3 + 20 x^2 + E3 x + 26
  multiply u_g5 (.a(fb), .b(8'h3F), .y(p5));
  multiply u_g4 (.a(fb), .b(8'h01), .y(p4));
  multiply u_g3 (.a(fb), .b(8'hDA), .y(p3));
  multiply u_g2 (.a(fb), .b(8'h20), .y(p2));
  multiply u_g1 (.a(fb), .b(8'hE3), .y(p1));
  multiply u_g0 (.a(fb), .b(8'h26), .y(p0));

  // Message pass-through with LFSR division, then parity drain; everything freezes on a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_MSG;
      msg_cnt        <= 8'd0;
      par_cnt        <= 3'd0;
      r5             <= 8'h00;
      r4             <= 8'h00;
      r3             <= 8'h00;
      r2             <= 8'h00;
      r1             <= 8'h00;
      r0             <= 8'h00;
      bus.out_data   <= 8'h00;
      bus.out_valid  <= 1'b0;
      bus.out_parity <= 1'b0;
      bus.out_last   <= 1'b0;
    end else if (free) begin
      if (state == ST_MSG) begin
        if (bus.in_valid) begin
          bus.out_data   <= bus.in_data;
          bus.out_valid  <= 1'b1;
          bus.out_parity <= 1'b0;
          bus.out_last   <= 1'b0;
          r5 <= r4 ^ p5;
          r4 <= r3 ^ p4;
          r3 <= r2 ^ p3;
          r2 <= r1 ^ p2;
          r1 <= r0 ^ p1;
          r0 <= p0;
          if (msg_cnt == MSG_LAST) begin
            msg_cnt <= 8'd0;
            state   <= ST_PAR;
          end else begin
            msg_cnt <= msg_cnt + 8'd1;
          end
        end else begin
          bus.out_valid <= 1'b0;
        end
      end else begin
        // Shifting zeros in leaves r5..r0 cleared after the sixth byte
        bus.out_data   <= r5;
        bus.out_valid  <= 1'b1;
        bus.out_parity <= 1'b1;
        bus.out_last   <= (par_cnt == 3'd5);
        r5 <= r4;
        r4 <= r3;
        r3 <= r2;
        r2 <= r1;
        r1 <= r0;
        r0 <= 8'h00;
        if (par_cnt == 3'd5) begin
          par_cnt <= 3'd0;
          state   <= ST_MSG;
        end else begin
          par_cnt <= par_cnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon encoder over GF(2^8): RS(K+6, K), 6 parity bytes, t = 3 correctable symbols. It is the transmit-side counterpart of the t = 3 decoder datapath: syndrome, 3x3 determinant and Chien/Forney. It accepts K message bytes on a valid/ready stream and emits those bytes unchanged, then 6 parity bytes. The parity is computed by an LFSR divider built from the existing `multiply` GF(2^8) multiplier.

## Interface
- `K`, default 249: message bytes per codeword; legal range 1..249.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `in_data` input 8: message byte.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: block accepts `in_data` this cycle.
- `out_data` output 8: codeword byte, registered.
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: downstream accepts `out_data`.
- `out_parity` output 1: current output byte is a parity byte.
- `out_last` output 1: current output byte is the final byte of the codeword (parity byte 6).

## Operation
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02. This is identical to `multiply`.
- Generator polynomial, with roots α^0..α^5: g(x) = x^6 + 3F·x^5 + 01·x^4 + DA·x^3 + 20·x^2 + E3·x + 26 (hex). Coefficients are constants; multiplies are six `multiply` instances with constant B.
- Parity registers are r5..r0, 8 bits each. r5 is the highest-degree register and is the first parity byte sent.
- Output register is free when `!out_valid || out_ready`.
- State MSG:
  - `in_ready` = free.
  - On accept (`in_valid && in_ready`): `out_data` <= `in_data`; `out_valid` <= 1; `out_parity` <= 0; `out_last` <= 0.
  - On accept, the LFSR step is fb = `in_data` ^ r5, then r5 <= r4 ^ fb·3F, r4 <= r3 ^ fb·01, r3 <= r2 ^ fb·DA, r2 <= r1 ^ fb·20, r1 <= r0 ^ fb·E3, r0 <= fb·26.
  - On accept, the byte count (8-bit) increments. On the K-th accept, the count clears and the state moves to PARITY.
- State PARITY:
  - `in_ready` = 0.
  - When free: `out_data` <= r5; `out_valid` <= 1; `out_parity` <= 1; the registers shift (r5 <= r4 … r1 <= r0, r0 <= 0); the parity count increments.
  - On the 6th parity load, `out_last` <= 1, the count clears and the state returns to MSG. After 6 shifts r5..r0 are all 0, with no separate clear.
- Free and no new load: `out_valid` <= 0.
- Stall (`out_valid && !out_ready`): `out_data`, `out_parity` and `out_last` hold stable; no state, count or LFSR change.
- Reset (any cycle, including mid-codeword): state = MSG, counts = 0, r5..r0 = 0. Outputs reset to `out_data` = 0, `out_valid` = 0, `out_parity` = 0, `out_last` = 0. `in_ready` = 1 after release. The partial codeword is discarded.

## Timing
- Latency: an input byte accepted at edge n appears on `out_data` with `out_valid` = 1 after edge n.
- `in_ready` is combinational from state and `out_valid`/`out_ready`; there is no combinational path from `in_valid` to `out_*`.
- Throughput with `out_ready` held at 1 is one byte per cycle: K+6 cycles per codeword. `in_ready` is low for exactly 6 cycles between codewords.
- The first parity byte loads on the first free edge after the K-th message accept.
- The next codeword's first byte can be accepted on the edge after the 6th parity load.
- K = 1: every message accept is immediately followed by PARITY.

## Test plan
- Single byte, unit message: K=1, `in_data`=01, `out_ready`=1 -> `out_data` sequence 01,3F,01,DA,20,E3,26. `out_parity` = 0,1,1,1,1,1,1; `out_last` is high only on 26.
- Back-to-back: K=1, messages 01 then 02 with `in_valid` held -> 01,3F,01,DA,20,E3,26,02,7E,02,A9,40,DB,4C. `in_ready` is low for 6 cycles between the two messages.
- All-zero message: K=249, all-zero input -> 255 zero bytes; `out_last` on byte 255; `out_parity` on bytes 250..255.
- Backpressure: K=1, message 01, pseudo-random `out_ready` -> same 7-byte stream as the unit-message test. `out_data`/flags are stable on every stalled cycle, and no byte is dropped or duplicated.
- Reset mid-parity: assert `rst_n`=0 after the 3rd parity byte of the unit-message test -> all outputs are 0 immediately (asynchronous). After release, message 02 produces 02,7E,02,A9,40,DB,4C.
- Random codewords: K=249, 100 random messages -> output is checked against a software golden encoder. Each codeword evaluates to 0 at α^0..α^5 (all syndromes zero).
